// File: rtl/serial_rx_deser.sv
// 8N1-style serial receiver: mid-bit sampling, start-glitch reject, framing/overrun flags,
// and a single-entry valid/ready holding register. serial_i must already be synchronous to clk_i.
module serial_rx_deser #(
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned ClksPerBit = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 serial_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned HalfBit = ClksPerBit / 2;
  localparam int unsigned CntW    = $clog2(ClksPerBit);
  localparam int unsigned BitW    = $clog2(DataWidth);

  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DataWidth - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [DataWidth-1:0]   shift_q, shift_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!serial_i) begin
          state_d = START;
          bit_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = serial_i ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {serial_i, shift_q[DataWidth-1:1]};
          if (bit_q == DataLast) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      STOP: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (serial_i) begin
            state_d = IDLE;
            // A same-cycle consume frees the slot, so the new word replaces it.
            if (!valid_q || ready_i) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (serial_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx_deser.sv
// Bench for serial_rx_deser: waveform-level reference model (frame positions decoded
// from the line by arithmetic) plus a holding-register model, checked every cycle.
module tb_serial_rx_deser;

  localparam int DW   = 8;
  localparam int C    = 16;
  localparam int H    = C / 2;
  localparam int MAXN = 4096;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          serial_i = 1'b1;
  logic          ready_i = 1'b1;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          frame_err_o;
  logic          overrun_o;
  logic          busy_o;

  serial_rx_deser #(.DataWidth(DW), .ClksPerBit(C)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .serial_i   (serial_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Segment stimulus and decoded expectations, indexed by clock edge.
  int            n;
  bit            line[MAXN];
  bit            rdy[MAXN];
  bit            good_ev[MAXN];
  bit            ferr_ev[MAXN];
  bit            busy_exp[MAXN];
  logic [DW-1:0] word_ev[MAXN];

  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  int            seg_first_valid;
  int            seg_rises;

  function automatic bit ln(input int i);
    return (i < n) ? line[i] : 1'b1;
  endfunction

  task automatic seg_clear();
    n = 0;
  endtask

  task automatic add(input bit v, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      line[n] = v;
      rdy[n]  = 1'b1;
      n++;
    end
  endtask

  task automatic frame(input logic [DW-1:0] b, input bit stopbit, output int t0);
    t0 = n;
    add(1'b0, C);
    for (int k = 0; k < DW; k++) add(b[k], C);
    add(stopbit, C);
  endtask

  task automatic fill_rdy(input int mode);
    for (int i = 0; i < n; i++)
      rdy[i] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'(($urandom % 2));
  endtask

  task automatic mark_busy(input int a, input int b);
    for (int i = a; i <= b; i++) if (i < MAXN) busy_exp[i] = 1'b1;
  endtask

  // Walk the line: find start edges, sample at the nominal mid-bit offsets.
  task automatic decode();
    int pos, t0, ts, j;
    logic [DW-1:0] w;
    for (int i = 0; i < MAXN; i++) begin
      good_ev[i] = 0; ferr_ev[i] = 0; busy_exp[i] = 0; word_ev[i] = '0;
    end
    pos = 0;
    while (pos < n) begin
      if (ln(pos)) begin
        pos++;
      end else begin
        t0 = pos;
        if (ln(t0 + H)) begin
          mark_busy(t0, t0 + H - 1);
          pos = t0 + H + 1;
        end else begin
          w = '0;
          for (int k = 0; k < DW; k++) w[k] = ln(t0 + H + (k + 1) * C);
          ts = t0 + H + (DW + 1) * C;
          if (ln(ts)) begin
            if (ts < MAXN) begin good_ev[ts] = 1; word_ev[ts] = w; end
            mark_busy(t0, ts - 1);
            pos = ts + 1;
          end else begin
            if (ts < MAXN) ferr_ev[ts] = 1;
            j = ts + 1;
            while (!ln(j)) j++;
            mark_busy(t0, j - 1);
            pos = j + 1;
          end
        end
      end
    end
  endtask

  task automatic run_segment(input int upto);
    logic prev_v;
    logic m_ferr, m_ovr;
    decode();
    seg_first_valid = -1;
    seg_rises = 0;
    prev_v = valid_o;
    for (int c = 0; c < upto && c < n; c++) begin
      @(negedge clk_i);
      serial_i = line[c];
      ready_i  = rdy[c];
      @(posedge clk_i);
      #1;
      m_ovr  = 1'b0;
      m_ferr = ferr_ev[c];
      if (good_ev[c]) begin
        if (!m_valid || rdy[c]) begin
          m_valid = 1'b1;
          m_data  = word_ev[c];
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rdy[c]) begin
        m_valid = 1'b0;
      end
      if (valid_o && !prev_v) begin
        seg_rises++;
        if (seg_first_valid < 0) seg_first_valid = c;
      end
      prev_v = valid_o;
      check("valid", 32'(valid_o), 32'(m_valid));
      check("data", 32'(data_o), 32'(m_data));
      check("frame_err", 32'(frame_err_o), 32'(m_ferr));
      check("overrun", 32'(overrun_o), 32'(m_ovr));
      check("busy", 32'(busy_o), 32'(busy_exp[c]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(data_o), 32'h0);
    check({tag, "_valid"}, 32'(valid_o), 32'h0);
    check({tag, "_ferr"}, 32'(frame_err_o), 32'h0);
    check({tag, "_ovr"}, 32'(overrun_o), 32'h0);
    check({tag, "_busy"}, 32'(busy_o), 32'h0);
  endtask

  initial begin
    int t0, t0b, kind, nf;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single frame, latency from start edge
    seg_clear(); add(1, 10); frame(8'hA5, 1'b1, t0); add(1, 20);
    run_segment(n);
    check("a5_latency", 32'(seg_first_valid), 32'(t0 + H + (DW + 1) * C));
    check("a5_data", 32'(data_o), 32'hA5);

    // Start glitch
    seg_clear(); add(1, 10); add(0, 5); add(1, 30);
    run_segment(n);
    check("glitch_no_valid", 32'(seg_rises), 32'h0);

    // Framing error with held-low line
    seg_clear(); add(1, 10); frame(8'h3C, 1'b0, t0); add(0, 40); add(1, 20);
    run_segment(n);
    check("ferr_no_valid", 32'(seg_rises), 32'h0);

    // Overrun while holding register is full
    seg_clear(); add(1, 10); frame(8'h11, 1'b1, t0); add(1, 5); frame(8'h22, 1'b1, t0b); add(1, 10);
    fill_rdy(1);
    run_segment(n);
    check("ovr_data_held", 32'(data_o), 32'h11);
    check("ovr_valid_held", 32'(valid_o), 32'h1);

    // Consume on exactly the reload cycle
    seg_clear(); add(1, 10); frame(8'h33, 1'b1, t0); add(1, 10);
    fill_rdy(1);
    rdy[t0 + H + (DW + 1) * C] = 1'b1;
    run_segment(n);
    check("reload_data", 32'(data_o), 32'h33);
    check("reload_valid", 32'(valid_o), 32'h1);
    seg_clear(); add(1, 5);
    run_segment(n);

    // Reset after three data bits
    seg_clear(); add(1, 10); frame(8'hFF, 1'b1, t0); add(1, 10);
    run_segment(t0 + H + 3 * C + 4);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midreset");
    m_valid = 1'b0;
    m_data  = '0;
    serial_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    seg_clear(); add(1, 10); frame(8'h5A, 1'b1, t0); add(1, 20);
    run_segment(n);
    check("after_reset_rises", 32'(seg_rises), 32'h1);
    check("after_reset_data", 32'(data_o), 32'h5A);

    // Back-to-back frames, no idle gap
    seg_clear(); add(1, 10);
    for (int i = 0; i < 6; i++) frame(8'($urandom), 1'b1, t0);
    add(1, 20);
    run_segment(n);
    check("b2b_count", 32'(seg_rises), 32'h6);

    // Randomized mix
    for (int s = 0; s < 30; s++) begin
      seg_clear();
      add(1, 1 + int'($urandom_range(0, 19)));
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: frame(8'($urandom), 1'b1, t0);
        1: begin
          frame(8'($urandom), 1'b0, t0);
          add(0, int'($urandom_range(0, 30)));
        end
        2: add(0, int'($urandom_range(1, H)));
        default: begin
          nf = int'($urandom_range(2, 4));
          for (int i = 0; i < nf; i++) frame(8'($urandom), 1'b1, t0);
        end
      endcase
      add(1, 30);
      fill_rdy(int'($urandom_range(0, 2)));
      run_segment(n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
